// File: rtl/time_set_ctrl.sv
// Time-setting controller: walks hr/min/sec/AM-PM edit fields from two buttons
// and strobes the edited time into the clock through a held load pulse.
module time_set_ctrl #(
  parameter int SET_HOLD = 4,
  parameter int TIMEOUT  = 1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        btn_mode,
  input  logic        btn_inc,
  input  logic [23:0] cur_time,
  input  logic        cur_AM,
  output logic [7:0]  hr,
  output logic [7:0]  min,
  output logic [7:0]  sec,
  output logic        dayNight,
  output logic        set,
  output logic        editing,
  output logic [1:0]  field_sel
);

  typedef enum logic [2:0] {
    IDLE, EDIT_HR, EDIT_MIN, EDIT_SEC, EDIT_AP, COMMIT
  } state_t;

  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT - 1);
  localparam logic [15:0] HOLD_CYCLES  = 16'(SET_HOLD);

  state_t      state_reg, state_next;
  logic [7:0]  hr_reg, hr_next;
  logic [7:0]  min_reg, min_next;
  logic [7:0]  sec_reg, sec_next;
  logic        day_night_reg, day_night_next;
  logic        set_reg, set_next;
  logic [15:0] cnt_reg, cnt_next;
  logic        mode_q_reg, inc_q_reg;
  logic        armed_reg;
  logic        mode_edge, inc_edge;

  function automatic logic [7:0] inc_hr(input logic [7:0] v);
    if (v == 8'h12)
      return 8'h01;
    else if (v[3:0] == 4'd9)
      return {v[7:4] + 4'd1, 4'd0};
    else
      return {v[7:4], v[3:0] + 4'd1};
  endfunction

  function automatic logic [7:0] inc_60(input logic [7:0] v);
    if (v == 8'h59)
      return 8'h00;
    else if (v[3:0] == 4'd9)
      return {v[7:4] + 4'd1, 4'd0};
    else
      return {v[7:4], v[3:0] + 4'd1};
  endfunction

  function automatic logic preload_ok(input logic [23:0] t);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < 6; i++)
      if (t[i*4 +: 4] > 4'd9) ok = 1'b0;
    if (t[23:16] == 8'h00 || t[23:16] > 8'h12) ok = 1'b0;
    if (t[15:8] > 8'h59 || t[7:0] > 8'h59) ok = 1'b0;
    return ok;
  endfunction

  // Edges are masked for one cycle after reset so a button held through
  // release does not look like a fresh press.
  assign mode_edge = armed_reg & btn_mode & ~mode_q_reg;
  assign inc_edge  = armed_reg & btn_inc  & ~inc_q_reg;

  always_comb begin
    state_next     = state_reg;
    hr_next        = hr_reg;
    min_next       = min_reg;
    sec_next       = sec_reg;
    day_night_next = day_night_reg;
    set_next       = 1'b0;
    cnt_next       = cnt_reg;

    case (state_reg)
      IDLE: begin
        cnt_next = '0;
        if (mode_edge) begin
          state_next     = EDIT_HR;
          day_night_next = cur_AM;
          if (preload_ok(cur_time)) begin
            hr_next  = cur_time[23:16];
            min_next = cur_time[15:8];
            sec_next = cur_time[7:0];
          end else begin
            hr_next  = 8'h12;
            min_next = 8'h00;
            sec_next = 8'h00;
          end
        end
      end

      EDIT_HR, EDIT_MIN, EDIT_SEC, EDIT_AP: begin
        // Mode wins over a coincident inc; any edge restarts the idle count.
        if (mode_edge) begin
          cnt_next = '0;
          case (state_reg)
            EDIT_HR:  state_next = EDIT_MIN;
            EDIT_MIN: state_next = EDIT_SEC;
            EDIT_SEC: state_next = EDIT_AP;
            default:  state_next = COMMIT;
          endcase
        end else if (inc_edge) begin
          cnt_next = '0;
          case (state_reg)
            EDIT_HR:  hr_next        = inc_hr(hr_reg);
            EDIT_MIN: min_next       = inc_60(min_reg);
            EDIT_SEC: sec_next       = inc_60(sec_reg);
            default:  day_night_next = ~day_night_reg;
          endcase
        end else if (cnt_reg == TIMEOUT_LAST) begin
          cnt_next   = '0;
          state_next = IDLE;
        end else begin
          cnt_next = cnt_reg + 16'd1;
        end
      end

      COMMIT: begin
        if (cnt_reg < HOLD_CYCLES) begin
          set_next = 1'b1;
          cnt_next = cnt_reg + 16'd1;
        end else begin
          cnt_next   = '0;
          state_next = IDLE;
        end
      end

      default: begin
        cnt_next   = '0;
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= IDLE;
      hr_reg        <= 8'h12;
      min_reg       <= 8'h00;
      sec_reg       <= 8'h00;
      day_night_reg <= 1'b1;
      set_reg       <= 1'b0;
      cnt_reg       <= '0;
      mode_q_reg    <= 1'b0;
      inc_q_reg     <= 1'b0;
      armed_reg     <= 1'b0;
    end else begin
      state_reg     <= state_next;
      hr_reg        <= hr_next;
      min_reg       <= min_next;
      sec_reg       <= sec_next;
      day_night_reg <= day_night_next;
      set_reg       <= set_next;
      cnt_reg       <= cnt_next;
      mode_q_reg    <= btn_mode;
      inc_q_reg     <= btn_inc;
      armed_reg     <= 1'b1;
    end
  end

  always_comb begin
    editing   = 1'b0;
    field_sel = 2'd0;
    case (state_reg)
      EDIT_HR:  begin editing = 1'b1; field_sel = 2'd0; end
      EDIT_MIN: begin editing = 1'b1; field_sel = 2'd1; end
      EDIT_SEC: begin editing = 1'b1; field_sel = 2'd2; end
      EDIT_AP:  begin editing = 1'b1; field_sel = 2'd3; end
      default:  begin editing = 1'b0; field_sel = 2'd0; end
    endcase
  end

  assign hr       = hr_reg;
  assign min      = min_reg;
  assign sec      = sec_reg;
  assign dayNight = day_night_reg;
  assign set      = set_reg;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Directed bench for time_set_ctrl: edit/commit, wraps, preload guard,
// simultaneous edges, idle timeout and reset during the load strobe.
module tb_time_set_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        btn_mode = 1'b0;
  logic        btn_inc = 1'b0;
  logic [23:0] cur_time = 24'h000000;
  logic        cur_AM = 1'b0;
  logic [7:0]  hr, min, sec;
  logic        dayNight, set, editing;
  logic [1:0]  field_sel;

  int n_checks = 0;
  int n_pass = 0;

  time_set_ctrl #(.SET_HOLD(4), .TIMEOUT(1000)) dut (
    .clk(clk), .reset(reset), .btn_mode(btn_mode), .btn_inc(btn_inc),
    .cur_time(cur_time), .cur_AM(cur_AM), .hr(hr), .min(min), .sec(sec),
    .dayNight(dayNight), .set(set), .editing(editing), .field_sel(field_sel)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [23:0] got, input logic [23:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
      $display("chk %-14s got %0h ok", tag, got);
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; leaves the bench at a negedge with outputs settled.
  task automatic press(input logic m, input logic i);
    btn_mode = m;
    btn_inc  = i;
    @(negedge clk);
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    btn_mode = 1'b0;
    btn_inc = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic check_time(input string tag, input logic [7:0] h, input logic [7:0] m,
                            input logic [7:0] s, input logic dn);
    check({tag, "_hr"}, {16'h0, hr}, {16'h0, h});
    check({tag, "_min"}, {16'h0, min}, {16'h0, m});
    check({tag, "_sec"}, {16'h0, sec}, {16'h0, s});
    check({tag, "_dn"}, {23'h0, dayNight}, {23'h0, dn});
  endtask

  initial begin
    int  highs;
    logic set_seen;

    do_reset();
    check_time("rst", 8'h12, 8'h00, 8'h00, 1'b1);
    check("rst_set", {23'h0, set}, 24'h0);
    check("rst_edit", {23'h0, editing}, 24'h0);
    check("rst_fsel", {22'h0, field_sel}, 24'h0);

    // Basic edit and commit
    cur_time = 24'h064030; cur_AM = 1'b1;
    press(1'b0, 1'b1);
    check("idle_inc_ign", {23'h0, editing}, 24'h0);
    check("idle_inc_hr", {16'h0, hr}, 24'h12);
    press(1'b1, 1'b0);
    check("pre_edit", {23'h0, editing}, 24'h1);
    check_time("pre", 8'h06, 8'h40, 8'h30, 1'b1);
    repeat (3) press(1'b0, 1'b1);
    check("hr_inc3", {16'h0, hr}, 24'h09);
    press(1'b1, 1'b0);
    check("fsel_min", {22'h0, field_sel}, 24'h1);
    press(1'b1, 1'b0);
    check("fsel_sec", {22'h0, field_sel}, 24'h2);
    press(1'b1, 1'b0);
    check("fsel_ap", {22'h0, field_sel}, 24'h3);
    btn_mode = 1'b1;
    @(negedge clk);
    check("commit_edit", {23'h0, editing}, 24'h0);
    check("commit_set0", {23'h0, set}, 24'h0);
    btn_mode = 1'b0;
    highs = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (set) begin
        highs++;
        if (hr !== 8'h09 || min !== 8'h40 || sec !== 8'h30 || dayNight !== 1'b1)
          check("set_stable", {hr, min, sec}, 24'h094030);
      end
    end
    check("set_len", 24'(highs), 24'd4);
    check_time("commit", 8'h09, 8'h40, 8'h30, 1'b1);
    check("commit_idle", {23'h0, editing}, 24'h0);

    // Wrap-around on every numeric field
    do_reset();
    cur_time = 24'h125909; cur_AM = 1'b0;
    press(1'b1, 1'b0);
    press(1'b0, 1'b1);
    check("wrap_hr", {16'h0, hr}, 24'h01);
    press(1'b1, 1'b0);
    press(1'b0, 1'b1);
    check("wrap_min", {16'h0, min}, 24'h00);
    press(1'b1, 1'b0);
    press(1'b0, 1'b1);
    check("carry_sec", {16'h0, sec}, 24'h10);

    // Invalid preloads and AM/PM toggle
    do_reset();
    cur_time = 24'h1A7799; cur_AM = 1'b0;
    press(1'b1, 1'b0);
    check_time("bad", 8'h12, 8'h00, 8'h00, 1'b0);
    repeat (3) press(1'b1, 1'b0);
    press(1'b0, 1'b1);
    check("ap_tog1", {23'h0, dayNight}, 24'h1);
    press(1'b0, 1'b1);
    check("ap_tog2", {23'h0, dayNight}, 24'h0);
    do_reset();
    cur_time = 24'h005959; cur_AM = 1'b1;
    press(1'b1, 1'b0);
    check("hr00_sub", {hr, min, sec}, 24'h120000);
    do_reset();
    cur_time = 24'h116000;
    press(1'b1, 1'b0);
    check("min60_sub", {hr, min, sec}, 24'h120000);

    // Simultaneous edges, then idle timeout
    do_reset();
    cur_time = 24'h064030; cur_AM = 1'b1;
    press(1'b1, 1'b0);
    press(1'b1, 1'b0);
    press(1'b1, 1'b1);
    check("simul_fsel", {22'h0, field_sel}, 24'h2);
    check("simul_min", {16'h0, min}, 24'h40);
    set_seen = 1'b0;
    for (int k = 0; k < 998; k++) begin
      @(negedge clk);
      if (set) set_seen = 1'b1;
    end
    check("to_not_yet", {23'h0, editing}, 24'h1);
    @(negedge clk);
    check("to_idle", {23'h0, editing}, 24'h0);
    check("to_no_set", {23'h0, set_seen}, 24'h0);
    check_time("to_hold", 8'h06, 8'h40, 8'h30, 1'b1);

    // Reset during the second set cycle
    do_reset();
    cur_time = 24'h031507; cur_AM = 1'b0;
    repeat (5) press(1'b1, 1'b0);
    check("rc_set1", {23'h0, set}, 24'h1);
    @(negedge clk);
    check("rc_set2", {23'h0, set}, 24'h1);
    #2 reset = 1'b0;
    #1;
    check("rc_async_set", {23'h0, set}, 24'h0);
    check_time("rc", 8'h12, 8'h00, 8'h00, 1'b1);
    check("rc_fsel", {22'h0, field_sel}, 24'h0);
    @(negedge clk);
    btn_mode = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("held_no_edge", {23'h0, editing}, 24'h0);
    btn_mode = 1'b0;
    @(negedge clk);
    press(1'b1, 1'b0);
    check("after_rel", {23'h0, editing}, 24'h1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/time_set_ctrl.md
TIME_SET_CTRL -- requirements
Module: time_set_ctrl

Interface
REQ-001 SHALL provide parameter SET_HOLD, default 4, number of cycles `set` is held high on commit (range 1-255).
REQ-002 SHALL provide parameter TIMEOUT, default 1000, idle cycles in an edit state before the edit is abandoned (range 2-65535).
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port btn_mode  input  1  debounced, clk-synchronous level; a rising edge advances the edit field.
REQ-006 SHALL have port btn_inc  input  1  debounced, clk-synchronous level; a rising edge increments the selected field.
REQ-007 SHALL have port cur_time  input  24  live clock time, BCD {hr,min,sec}, used as the edit starting point.
REQ-008 SHALL have port cur_AM  input  1  live clock AM flag, loaded as the dayNight starting value.
REQ-009 SHALL have ports hr, min, sec  output  8 each  registered BCD set values driven to the clock's set inputs.
REQ-010 SHALL have port dayNight  output  1  registered AM/PM set value, same polarity as cur_AM.
REQ-011 SHALL have port set  output  1  registered load strobe to the clock.
REQ-012 SHALL have port editing  output  1  high while in any EDIT state.
REQ-013 SHALL have port field_sel  output  2  selected field: 0 hr, 1 min, 2 sec, 3 AM/PM.

Function
REQ-014 SHALL define a rising edge as input high this cycle and low in the previous cycle, using one internal register per button.
REQ-015 SHALL implement the states IDLE, EDIT_HR, EDIT_MIN, EDIT_SEC, EDIT_AP and COMMIT.
REQ-016 In IDLE, a btn_mode edge SHALL load hr/min/sec/dayNight from cur_time/cur_AM and enter EDIT_HR on the next cycle.
REQ-017 In IDLE, btn_inc SHALL be ignored.
REQ-018 The preload SHALL substitute 12:00:00 and keep cur_AM if any cur_time nibble exceeds 9, hr is 00 or above 12, or min/sec is above 59.
REQ-019 A btn_mode edge SHALL advance the edit states EDIT_HR->EDIT_MIN->EDIT_SEC->EDIT_AP->COMMIT.
REQ-020 A btn_inc edge in EDIT_HR SHALL step hr through BCD 01..12, wrapping 12->01.
REQ-021 A btn_inc edge in EDIT_MIN or EDIT_SEC SHALL step the field through BCD 00..59, wrapping 59->00; low-nibble 9->0 SHALL carry into the high nibble.
REQ-022 A btn_inc edge in EDIT_AP SHALL toggle dayNight.
REQ-023 Every field update SHALL be visible on the outputs one cycle after the sampled edge.
REQ-024 When btn_mode and btn_inc edges occur in the same cycle, btn_mode SHALL take priority and btn_inc SHALL be discarded.
REQ-025 Each edit state SHALL keep an idle counter that is cleared on entry and on any button edge.
REQ-026 When the idle counter reaches TIMEOUT, the block SHALL return to IDLE without asserting set; hr/min/sec/dayNight SHALL hold their last values.
REQ-027 COMMIT SHALL drive set high for exactly SET_HOLD consecutive cycles, beginning the cycle after entry, then return to IDLE.
REQ-028 hr/min/sec/dayNight SHALL be stable for the whole set window.
REQ-029 All button edges in COMMIT SHALL be ignored.
REQ-030 editing SHALL be high only in the EDIT states.
REQ-031 field_sel SHALL equal the current edit field, and SHALL be 0 in IDLE and COMMIT.

Reset
REQ-032 Asserting reset low SHALL asynchronously force IDLE, hr=8'h12, min=8'h00, sec=8'h00, dayNight=1, set=0, editing=0, field_sel=0, and clear the button edge history and all counters.
REQ-033 Reset asserted mid-edit or mid-COMMIT SHALL drop set in the same instant, and a button held high through reset release SHALL NOT produce an edge.

Verification
REQ-034 Basic edit and commit: cur_time=24'h064030, cur_AM=1; mode, 3 inc, mode, mode, mode, mode edges -> hr=09, min=40, sec=30, dayNight=1, set high for 4 cycles, then IDLE.
REQ-035 Wrap-around: in EDIT_HR from 12, 1 inc -> hr=01; in EDIT_MIN from 59, 1 inc -> min=00; in EDIT_SEC from 09, 1 inc -> sec=10.
REQ-036 Invalid preload and AM/PM toggle: cur_time=24'h1A7799, mode edge -> hr=12, min=00, sec=00; in EDIT_AP, 2 inc edges -> dayNight returns to its start value.
REQ-037 Simultaneous edges and timeout: mode and inc rising in the same cycle in EDIT_MIN -> EDIT_SEC with min unchanged; then no edges for 1000 cycles -> IDLE, set never asserted.
REQ-038 Reset mid-COMMIT: reset low during the 2nd set cycle -> set=0 immediately, all outputs at reset values; btn_mode held high across release -> remains IDLE.
